puf_challenge_driver: RTL and testbench

Initiator/verifier side of the arbiter-PUF challenge-response interface. Accepts a challenge over a valid/ready handshake and drives it onto the PUF challenge lines. Fires a programmable number of excitation pulses, samples the PUF response after each pulse through a synchronizer, and majority-votes the samples. Returns one stable response word per challenge, placed between the chip-level I/O logic and the PUF array.

---
 rtl/puf_pkg.sv | 26 ++
 rtl/puf_resp_sync.sv | 29 ++
 rtl/puf_challenge_driver.sv | 192 +++++++++++++++++++
 tb/tb_puf_challenge_driver.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared types and defaults for the arbiter-PUF challenge driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package puf_pkg;

   localparam int C_LENGTH_DEF = 8;
   localparam int RESP_W_DEF   = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_FIRE   = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_RELAX  = 3'd4,
      ST_DONE   = 3'd5
   } puf_state_e;

   // Bits needed to hold any count in 0..n.
   function automatic int cnt_w(input int n);
      if (n < 1) begin
         return 1;
      end
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/puf_resp_sync.sv
// Two-flop synchronizer for the asynchronous PUF arbiter outputs.
// Latency: 2 clk cycles from input change to sync_o.
// Backpressure: none; samples every cycle.
module puf_resp_sync #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // Capture stage followed by the resolution stage.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/puf_challenge_driver.sv
// Drives a challenge onto the PUF, fires NREP pulses, majority-votes the synchronized samples.
// Latency: response valid SETTLE + NREP*(2*SETTLE+1) cycles after challenge accept (49 at defaults).
// Backpressure: ch_ready low outside IDLE; response held in DONE until resp_ready.
// Build option: define PUF_STABILITY_EN to produce the per-bit instability mask.
module puf_challenge_driver
   import puf_pkg::*;
#(
   parameter int C_LENGTH = C_LENGTH_DEF,
   parameter int RESP_W   = RESP_W_DEF,
   parameter int NREP     = 5,
   parameter int SETTLE   = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ch_valid,
   output logic                ch_ready,
   input  logic [C_LENGTH-1:0] ch_data,
   output logic [C_LENGTH-1:0] puf_challenge,
   output logic                puf_pulse,
   input  logic [RESP_W-1:0]   puf_response,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [RESP_W-1:0]   resp_data,
   output logic [RESP_W-1:0]   resp_unstable,
   output logic                busy
);

   localparam int VOTE_W  = cnt_w(NREP);
   localparam int REP_W   = cnt_w(NREP);
   localparam int PHASE_W = cnt_w(SETTLE - 1);

   generate
      if ((NREP < 1) || ((NREP % 2) == 0)) begin : g_bad_nrep
         $error("puf_challenge_driver: NREP must be odd and >= 1");
      end
      if (SETTLE < 3) begin : g_bad_settle
         $error("puf_challenge_driver: SETTLE must be >= 3");
      end
   endgenerate

   puf_state_e                     state_q;
   logic [PHASE_W-1:0]             phase_q;
   logic [REP_W-1:0]               rep_q;
   logic [RESP_W-1:0][VOTE_W-1:0]  vote_q;
   logic [C_LENGTH-1:0]            chal_q;
   logic                           pulse_q;
   logic                           ch_ready_q;
   logic                           busy_q;
   logic                           resp_valid_q;
   logic [RESP_W-1:0]              resp_data_q;
   logic [RESP_W-1:0]              resp_data_d;
   logic [RESP_W-1:0]              resp_sync;
   logic                           phase_last;
   logic                           enter_done;

   // Raw arbiter outputs are asynchronous; nothing downstream sees them unsynchronized.
   puf_resp_sync #(
      .WIDTH (RESP_W)
   ) u_resp_sync (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .async_i (puf_response),
      .sync_o  (resp_sync)
   );

   assign phase_last = (phase_q == PHASE_W'(SETTLE - 1));
   assign enter_done = (state_q == ST_RELAX) && phase_last && (rep_q == REP_W'(NREP));

   // Per-bit majority decision over the accumulated votes.
   always_comb begin
      resp_data_d = '0;
      for (int i = 0; i < RESP_W; i++) begin
         resp_data_d[i] = (vote_q[i] > VOTE_W'(NREP / 2));
      end
   end

   // Sequencer: challenge latch, pulse timing, vote accumulation and response hand-off.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         phase_q      <= '0;
         rep_q        <= '0;
         vote_q       <= '0;
         chal_q       <= '0;
         pulse_q      <= 1'b0;
         ch_ready_q   <= 1'b1;
         busy_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (ch_valid && ch_ready_q) begin
                  chal_q     <= ch_data;
                  vote_q     <= '0;
                  rep_q      <= '0;
                  phase_q    <= '0;
                  ch_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (phase_last) begin
                  phase_q <= '0;
                  pulse_q <= 1'b1;
                  state_q <= ST_FIRE;
               end else begin
                  phase_q <= phase_q + PHASE_W'(1);
               end
            end
            ST_FIRE: begin
               if (phase_last) begin
                  phase_q <= '0;
                  state_q <= ST_SAMPLE;
               end else begin
                  phase_q <= phase_q + PHASE_W'(1);
               end
            end
            ST_SAMPLE: begin
               // Pulse is still high this cycle; it drops as we enter RELAX.
               for (int i = 0; i < RESP_W; i++) begin
                  vote_q[i] <= vote_q[i] + VOTE_W'(resp_sync[i]);
               end
               rep_q   <= rep_q + REP_W'(1);
               pulse_q <= 1'b0;
               state_q <= ST_RELAX;
            end
            ST_RELAX: begin
               if (phase_last) begin
                  phase_q <= '0;
                  if (enter_done) begin
                     resp_valid_q <= 1'b1;
                     resp_data_q  <= resp_data_d;
                     state_q      <= ST_DONE;
                  end else begin
                     pulse_q <= 1'b1;
                     state_q <= ST_FIRE;
                  end
               end else begin
                  phase_q <= phase_q + PHASE_W'(1);
               end
            end
            ST_DONE: begin
               if (resp_valid_q && resp_ready) begin
                  resp_valid_q <= 1'b0;
                  ch_ready_q   <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef PUF_STABILITY_EN
   logic [RESP_W-1:0] resp_unstable_d;
   logic [RESP_W-1:0] resp_unstable_q;

   // A bit is unstable when its samples were not unanimous.
   always_comb begin
      resp_unstable_d = '0;
      for (int i = 0; i < RESP_W; i++) begin
         resp_unstable_d[i] = (vote_q[i] != '0) && (vote_q[i] != VOTE_W'(NREP));
      end
   end

   // Mask is captured on the same edge as resp_data and held through DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_unstable_q <= '0;
      end else if (enter_done) begin
         resp_unstable_q <= resp_unstable_d;
      end
   end

   assign resp_unstable = resp_unstable_q;
`else
   assign resp_unstable = '0;
`endif

   assign ch_ready      = ch_ready_q;
   assign busy          = busy_q;
   assign puf_challenge = chal_q;
   assign puf_pulse     = pulse_q;
   assign resp_valid    = resp_valid_q;
   assign resp_data     = resp_data_q;

endmodule

// File: tb/tb_puf_challenge_driver.sv
// Self-checking bench: randomized PUF behaviour against a majority-vote reference model.
// Covers reset state, latency, pulse windows, noisy votes, backpressure, mid-run reset,
// back-to-back traffic and a NREP=1/SETTLE=3 instance.
`timescale 1ns/1ps
module tb_puf_challenge_driver;

   localparam int CL      = 8;
   localparam int RW      = 8;
   localparam int NREP    = 5;
   localparam int SETTLE  = 4;
   localparam int LAT     = SETTLE + NREP * (2 * SETTLE + 1);
   localparam int NREP2   = 1;
   localparam int SETTLE2 = 3;
   localparam int LAT2    = SETTLE2 + NREP2 * (2 * SETTLE2 + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;

   logic          ch_valid = 1'b0;
   logic          ch_ready;
   logic [CL-1:0] ch_data = '0;
   logic [CL-1:0] puf_challenge;
   logic          puf_pulse;
   logic [RW-1:0] puf_response;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [RW-1:0] resp_data;
   logic [RW-1:0] resp_unstable;
   logic          busy;

   logic          ch_valid2 = 1'b0;
   logic          ch_ready2;
   logic [CL-1:0] ch_data2 = '0;
   logic [CL-1:0] puf_challenge2;
   logic          puf_pulse2;
   logic [RW-1:0] puf_response2;
   logic          resp_valid2;
   logic          resp_ready2 = 1'b0;
   logic [RW-1:0] resp_data2;
   logic [RW-1:0] resp_unstable2;
   logic          busy2;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int last_hs = 0;

   // PUF model: per-repetition response words, selected by count of pulse rises.
   logic [NREP*RW-1:0] pats = '0;
   logic [RW-1:0]      pat2 = '0;
   int pcnt  = 0;
   int pbase = 0;

   logic [CL-1:0] prev_chal = '0;
   int chal_pulse_viol = 0;

   puf_challenge_driver u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ch_valid      (ch_valid),
      .ch_ready      (ch_ready),
      .ch_data       (ch_data),
      .puf_challenge (puf_challenge),
      .puf_pulse     (puf_pulse),
      .puf_response  (puf_response),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_data     (resp_data),
      .resp_unstable (resp_unstable),
      .busy          (busy)
   );

   puf_challenge_driver #(
      .NREP   (NREP2),
      .SETTLE (SETTLE2)
   ) u_dut2 (
      .clk           (clk),
      .rst_n         (rst_n),
      .ch_valid      (ch_valid2),
      .ch_ready      (ch_ready2),
      .ch_data       (ch_data2),
      .puf_challenge (puf_challenge2),
      .puf_pulse     (puf_pulse2),
      .puf_response  (puf_response2),
      .resp_valid    (resp_valid2),
      .resp_ready    (resp_ready2),
      .resp_data     (resp_data2),
      .resp_unstable (resp_unstable2),
      .busy          (busy2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge puf_pulse) pcnt = pcnt + 1;

   function automatic logic [RW-1:0] resp_model(input int pc, input int pb,
                                                input logic [NREP*RW-1:0] p, input logic pulse);
      int k;
      k = pc - pb - 1;
      if (k < 0) k = 0;
      if (k > NREP - 1) k = NREP - 1;
      return pulse ? p[k*RW +: RW] : ~p[k*RW +: RW];
   endfunction

   assign puf_response  = resp_model(pcnt, pbase, pats, puf_pulse);
   assign puf_response2 = puf_pulse2 ? pat2 : ~pat2;

   // The challenge lines must never move while a pulse is being driven.
   always @(negedge clk) begin
      if (puf_pulse === 1'b1 && puf_challenge !== prev_chal) chal_pulse_viol++;
      prev_chal = puf_challenge;
   end

   function automatic logic [RW-1:0] exp_vote(input logic [NREP*RW-1:0] p);
      logic [RW-1:0] v;
      int c;
      v = '0;
      for (int b = 0; b < RW; b++) begin
         c = 0;
         for (int r = 0; r < NREP; r++) c += int'(p[r*RW + b]);
         v[b] = (c > NREP / 2);
      end
      return v;
   endfunction

   function automatic logic [RW-1:0] exp_unstable(input logic [NREP*RW-1:0] p);
      logic [RW-1:0] v;
      int c;
      v = '0;
`ifdef PUF_STABILITY_EN
      for (int b = 0; b < RW; b++) begin
         c = 0;
         for (int r = 0; r < NREP; r++) c += int'(p[r*RW + b]);
         v[b] = (c != 0) && (c != NREP);
      end
`else
      c = 0;
`endif
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic randomize_pats();
      for (int r = 0; r < NREP; r++) pats[r*RW +: RW] = RW'($urandom);
   endtask

   // Called at a negedge; returns the cycle stamp of the accepting edge.
   task automatic issue(input logic [CL-1:0] ch, output int acc);
      int t;
      t = 0;
      pbase = pcnt;
      while (ch_ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("issue_ready", ch_ready, 1);
      ch_valid = 1'b1;
      ch_data  = ch;
      @(posedge clk);
      #1;
      ch_valid = 1'b0;
      ch_data  = CL'($urandom);
      @(negedge clk);
      acc = cyc;
      check("challenge_latched", puf_challenge, ch);
   endtask

   task automatic wait_resp(input int acc, input logic [CL-1:0] ch);
      int t, hi, rises, moved;
      logic prev;
      t = 0; hi = 0; rises = 0; moved = 0; prev = 1'b0;
      while (resp_valid !== 1'b1 && t < 300) begin
         if (puf_pulse === 1'b1) hi++;
         if (puf_pulse === 1'b1 && !prev) rises++;
         prev = puf_pulse;
         if (puf_challenge !== ch) moved++;
         @(negedge clk);
         t++;
      end
      check("latency", cyc - acc, LAT);
      check("resp_data", resp_data, exp_vote(pats));
      check("resp_unstable", resp_unstable, exp_unstable(pats));
      check("pulse_high_cycles", hi, NREP * (SETTLE + 1));
      check("pulse_count", rises, NREP);
      check("challenge_held", moved, 0);
      check("ready_low_in_done", ch_ready, 0);
   endtask

   task automatic ack(input int hold);
      int bad;
      logic [RW-1:0] d0;
      bad = 0;
      d0 = resp_data;
      repeat (hold) begin
         @(negedge clk);
         if (resp_data !== d0 || resp_valid !== 1'b1 || ch_ready !== 1'b0) bad++;
      end
      check("hold_stable", bad, 0);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      @(negedge clk);
      last_hs = cyc;
      check("valid_cleared", resp_valid, 0);
      check("ready_after_hs", ch_ready, 1);
   endtask

   initial begin
      int acc, acc2, t, bad;
      logic [CL-1:0] ch;
      logic [RW-1:0] d0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ch_ready", ch_ready, 1);
      check("rst_pulse", puf_pulse, 0);
      check("rst_challenge", puf_challenge, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_unstable", resp_unstable, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Ideal PUF: constant 0xA5 while pulsing
      for (int r = 0; r < NREP; r++) pats[r*RW +: RW] = 8'hA5;
      issue(8'h3C, acc);
      check("busy_after_accept", busy, 1);
      wait_resp(acc, 8'h3C);
      check("ideal_value", resp_data, 8'hA5);
      ack(2);

      // Noisy bit0: 1 on reps 1,3,5
      for (int r = 0; r < NREP; r++) pats[r*RW +: RW] = (r % 2 == 0) ? 8'h01 : 8'h00;
      issue(8'h5A, acc);
      wait_resp(acc, 8'h5A);
      check("noisy_value", resp_data, 8'h01);
      ack(0);

      // Random traffic with random response hold-off
      for (int n = 0; n < 8; n++) begin
         randomize_pats();
         ch = CL'($urandom);
         issue(ch, acc);
         wait_resp(acc, ch);
         ack(int'($urandom_range(0, 5)));
      end

      // Backpressure: response frozen, 0x55 ignored until after the handshake
      randomize_pats();
      issue(8'hC3, acc);
      wait_resp(acc, 8'hC3);
      d0 = resp_data;
      bad = 0;
      randomize_pats();
      pbase = pcnt;
      ch_valid = 1'b1;
      ch_data  = 8'h55;
      repeat (20) begin
         @(negedge clk);
         if (resp_data !== d0 || resp_valid !== 1'b1 || ch_ready !== 1'b0 ||
             puf_challenge !== 8'hC3) bad++;
      end
      check("bp_frozen", bad, 0);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      @(negedge clk);
      check("bp_ready_after_hs", ch_ready, 1);
      check("bp_not_taken_at_hs", puf_challenge, 8'hC3);
      @(posedge clk);
      #1;
      ch_valid = 1'b0;
      @(negedge clk);
      acc = cyc;
      check("bp_accept_next_cycle", puf_challenge, 8'h55);
      check("bp_busy", busy, 1);
      wait_resp(acc, 8'h55);
      ack(1);

      // Reset during the third FIRE
      for (int r = 0; r < NREP; r++) pats[r*RW +: RW] = 8'hFF;
      issue(8'h99, acc);
      t = 0;
      while ((pcnt - pbase) < 3 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("third_pulse_seen", puf_pulse, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_pulse", puf_pulse, 0);
      check("rst_mid_valid", resp_valid, 0);
      check("rst_mid_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_mid_ready", ch_ready, 1);
      randomize_pats();
      issue(8'h81, acc);
      wait_resp(acc, 8'h81);
      ack(0);

      // Back-to-back challenges 0x00..0x0F
      for (int n = 0; n < 16; n++) begin
         randomize_pats();
         issue(CL'(n), acc);
         if (n > 0) check("b2b_accept_gap", acc - last_hs, 1);
         wait_resp(acc, CL'(n));
         ack(0);
      end

      // Single-pulse, short-settle instance
      for (int n = 0; n < 4; n++) begin
         pat2 = RW'($urandom);
         ch   = CL'($urandom);
         t = 0;
         while (ch_ready2 !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
         end
         ch_valid2 = 1'b1;
         ch_data2  = ch;
         @(posedge clk);
         #1;
         ch_valid2 = 1'b0;
         @(negedge clk);
         acc2 = cyc;
         check("n1_challenge", puf_challenge2, ch);
         t = 0;
         while (resp_valid2 !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
         end
         check("n1_latency", cyc - acc2, LAT2);
         check("n1_resp_data", resp_data2, pat2);
         check("n1_unstable", resp_unstable2, 0);
         resp_ready2 = 1'b1;
         @(posedge clk);
         #1;
         resp_ready2 = 1'b0;
         @(negedge clk);
         check("n1_valid_cleared", resp_valid2, 0);
      end

      check("chal_change_during_pulse", chal_pulse_viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
